// File: rtl/vga_sync_decoder_if.sv
// rtl/vga_sync_decoder_if.sv - pixel counter in, decoded sync/blank/pulse outputs
interface vga_sync_decoder_if;
    logic [8:0] h_count;
    logic [9:0] v_count;
    logic       h_sync;
    logic       v_sync;
    logic       blank;
    logic       line_start;
    logic       frame_start;
    logic       seq_err;

    modport master (
        output h_count,
        input  v_count, h_sync, v_sync, blank, line_start, frame_start, seq_err
    );

    modport slave (
        input  h_count,
        output v_count, h_sync, v_sync, blank, line_start, frame_start, seq_err
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - tracks the line of a free-running pixel counter and
// registers VGA sync/blank/pulse decode, flagging illegal counter steps
module vga_sync_decoder #(
    parameter int H_VIS     = 200,
    parameter int H_FP      = 10,
    parameter int H_SYNC    = 32,
    parameter int H_TOTAL   = 264,
    parameter int V_VIS     = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_TOTAL   = 628,
    parameter bit HS_ACTIVE = 1'b1,
    parameter bit VS_ACTIVE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    vga_sync_decoder_if.slave  bus
);

    localparam logic [9:0]  H_VIS_W   = 10'(H_VIS);
    localparam logic [9:0]  HS_START  = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END    = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  H_TOTAL_W = 10'(H_TOTAL);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [10:0] V_VIS_W   = 11'(V_VIS);
    localparam logic [10:0] VS_START  = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

    logic [8:0]  h_prev_q, h_prev_d;
    logic        prev_valid_q, prev_valid_d;
    logic [9:0]  v_count_q, v_count_d;
    logic        h_sync_q, h_sync_d;
    logic        v_sync_q, v_sync_d;
    logic        blank_q, blank_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        seq_err_q, seq_err_d;

    logic [9:0]  h_ext;
    logic [9:0]  prev_ext;
    logic [10:0] line;
    logic        in_range;
    logic        step_ok;
    logic        advance;

    always_comb begin
        h_ext    = {1'b0, bus.h_count};
        prev_ext = {1'b0, h_prev_q};
        in_range = h_ext < H_TOTAL_W;
        // 10-bit increment so h_prev=511 can never match a 9-bit sample
        step_ok  = !prev_valid_q
                 || (h_ext == prev_ext + 10'd1)
                 || (prev_ext == H_LAST && h_ext == 10'd0);
        advance  = step_ok && in_range && (h_ext == H_LAST);

        v_count_d = v_count_q;
        if (advance) begin
            v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
        end

        // Decode against the post-update line so h=0 already sees the new line
        line          = {1'b0, v_count_d};
        seq_err_d     = !step_ok || !in_range;
        h_sync_d      = (in_range && h_ext >= HS_START && h_ext < HS_END) ? HS_ACTIVE : ~HS_ACTIVE;
        v_sync_d      = (line >= VS_START && line < VS_END) ? VS_ACTIVE : ~VS_ACTIVE;
        blank_d       = !in_range || (h_ext >= H_VIS_W) || (line >= V_VIS_W);
        line_start_d  = (h_ext == 10'd0);
        frame_start_d = (h_ext == 10'd0) && (line == 11'd0);
        h_prev_d      = bus.h_count;
        prev_valid_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_prev_q      <= '0;
            prev_valid_q  <= 1'b0;
            v_count_q     <= '0;
            h_sync_q      <= ~HS_ACTIVE;
            v_sync_q      <= ~VS_ACTIVE;
            blank_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            h_prev_q      <= h_prev_d;
            prev_valid_q  <= prev_valid_d;
            v_count_q     <= v_count_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign bus.v_count     = v_count_q;
    assign bus.h_sync      = h_sync_q;
    assign bus.v_sync      = v_sync_q;
    assign bus.blank       = blank_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder, both sync
// polarities, with the frame shortened to 28 lines (20 visible, sync on 21..24)
module tb_vga_sync_decoder;

    localparam int VT = 28;

    typedef struct {
        int v;
        bit hs;
        bit vs;
        bit bl;
        bit ls;
        bit fs;
        bit err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] hc  = '0;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb[$];

    int m_v    = 0;
    int m_prev = 0;
    bit m_pv   = 1'b0;

    int ln_hs, ln_ls, ln_bl, err_cnt, fr_blank, fr_fs;
    logic [31:0] vs_mask;

    always #5 clk = ~clk;

    vga_sync_decoder_if ifp ();
    vga_sync_decoder_if ifn ();

    assign ifp.h_count = hc;
    assign ifn.h_count = hc;

    vga_sync_decoder #(
        .V_VIS(20), .V_FP(1), .V_SYNC(4), .V_TOTAL(VT)
    ) dut_p (
        .clk(clk), .rst(rst), .bus(ifp.slave)
    );

    vga_sync_decoder #(
        .V_VIS(20), .V_FP(1), .V_SYNC(4), .V_TOTAL(VT),
        .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .bus(ifn.slave)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: presents one sample, records its expected decode,
    // and returns at the following negedge.
    task automatic drive(input int h);
        exp_t e;
        bit   legal;
        legal = !m_pv || (h == m_prev + 1) || (m_prev == 263 && h == 0);
        e.err = !legal || (h >= 264);
        if (!e.err && h == 263) m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        e.v   = m_v;
        e.hs  = (h >= 210 && h < 242);
        e.vs  = (m_v >= 21 && m_v < 25);
        e.bl  = (h >= 200) || (m_v >= 20);
        e.ls  = (h == 0);
        e.fs  = (h == 0) && (m_v == 0);
        m_prev = h;
        m_pv   = 1'b1;
        hc = 9'(h);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drive_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) drive(i);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_v_count"}, ifp.v_count, 0);
        chk({tag, "_hs_p"},    ifp.h_sync, 0);
        chk({tag, "_hs_n"},    ifn.h_sync, 1);
        chk({tag, "_vs_p"},    ifp.v_sync, 0);
        chk({tag, "_vs_n"},    ifn.v_sync, 1);
        chk({tag, "_blank"},   ifp.blank, 1);
        chk({tag, "_ls"},      ifp.line_start, 0);
        chk({tag, "_fs"},      ifp.frame_start, 0);
        chk({tag, "_err"},     ifp.seq_err, 0);
    endtask

    task automatic model_reset();
        m_v  = 0;
        m_prev = 0;
        m_pv = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb.size() > 0) begin
                e = sb.pop_front();
                chk("v_count_p", ifp.v_count, e.v);
                chk("v_count_n", ifn.v_count, e.v);
                chk("h_sync_p",  ifp.h_sync, e.hs);
                chk("h_sync_n",  ifn.h_sync, !e.hs);
                chk("v_sync_p",  ifp.v_sync, e.vs);
                chk("v_sync_n",  ifn.v_sync, !e.vs);
                chk("blank",     ifp.blank, e.bl);
                chk("line_start",  ifp.line_start, e.ls);
                chk("frame_start", ifp.frame_start, e.fs);
                chk("seq_err",   ifp.seq_err, e.err);
                ln_hs    += int'(ifp.h_sync);
                ln_ls    += int'(ifp.line_start);
                ln_bl    += int'(ifp.blank);
                err_cnt  += int'(ifp.seq_err);
                fr_blank += int'(ifp.blank);
                fr_fs    += int'(ifp.frame_start);
                if (ifp.v_sync) vs_mask |= 32'd1 << ifp.v_count;
            end
        end
    end

    initial begin : stimulus
        ln_hs = 0; ln_ls = 0; ln_bl = 0; err_cnt = 0;
        fr_blank = 0; fr_fs = 0; vs_mask = '0;

        @(negedge clk);
        #1;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Line 0: horizontal decode and first advance
        drive_range(0, 263);
        chk("line0_v_count", ifp.v_count, 1);
        chk("line0_hs_cycles", ln_hs, 32);
        chk("line0_ls_pulses", ln_ls, 1);
        chk("line0_blank_cycles", ln_bl, 64);

        // Rest of the frame, then wrap into line 0
        for (int ln = 1; ln < VT; ln++) drive_range(0, 263);
        chk("wrap_v_count", ifp.v_count, 0);
        chk("frame_blank_cycles", fr_blank, 20 * 64 + 8 * 264);
        chk("frame_vs_lines", int'(vs_mask), int'(32'h01E0_0000));
        chk("frame_fs_first", fr_fs, 1);
        drive(0);
        chk("wrap_frame_start", ifp.frame_start, 1);
        chk("frame_fs_total", fr_fs, 2);

        // Jump inside a line
        drive_range(1, 9);
        err_cnt = 0;
        drive_range(10, 12);
        drive(50);
        chk("jump_err_now", ifp.seq_err, 1);
        drive(51);
        chk("jump_err_next", ifp.seq_err, 0);
        chk("jump_err_total", err_cnt, 1);
        chk("jump_v_count", ifp.v_count, 0);

        // Out of range, then a 0 that does not follow 263
        drive(300);
        chk("oor_err", ifp.seq_err, 1);
        chk("oor_blank", ifp.blank, 1);
        chk("oor_hs", ifp.h_sync, 0);
        drive(0);
        chk("oor_next_err", ifp.seq_err, 1);
        chk("oor_err_total", err_cnt, 3);
        drive_range(1, 263);
        chk("resync_v_count", ifp.v_count, 1);

        // Run to line 15 pixel 100, then reset asynchronously mid-line
        for (int ln = 1; ln < 15; ln++) drive_range(0, 263);
        drive_range(0, 100);
        chk("pre_reset_v_count", ifp.v_count, 15);
        rst = 1'b1;
        #1;
        chk_reset("mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(57);
        chk("post_reset_err", ifp.seq_err, 0);
        chk("post_reset_v_count", ifp.v_count, 0);
        drive_range(58, 263);
        chk("post_reset_advance", ifp.v_count, 1);

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Consumes the free-running 9-bit horizontal pixel counter and tracks the vertical line it belongs to.
- Decodes both counters into registered h_sync, v_sync, blank, line_start and frame_start for the VGA output stage.
- Checks that the incoming h_count sequence is legal and flags any break.
- Timing defaults are 800x600@60 scaled to a 10 MHz pixel clock: 200 visible pixels, 600 visible lines.

Parameters:
H_VIS, 200, visible pixels per line
H_FP, 10, horizontal front porch (pixels)
H_SYNC, 32, horizontal sync width (pixels)
H_TOTAL, 264, pixels per line; must be <= 512
V_VIS, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_TOTAL, 628, lines per frame; must be <= 1024
HS_ACTIVE, 1, asserted level of h_sync
VS_ACTIVE, 1, asserted level of v_sync

Ports:
clk  input  1  pixel clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
h_count  input  9  current pixel column from horizontal counter
v_count  output  10  current line number, 0..V_TOTAL-1
h_sync  output  1  horizontal sync, registered
v_sync  output  1  vertical sync, registered
blank  output  1  1 = outside visible area, registered
line_start  output  1  1-cycle pulse, first pixel of a line
frame_start  output  1  1-cycle pulse, first pixel of a frame
seq_err  output  1  1-cycle pulse, illegal h_count step

Behaviour:
- Reset (async, while rst=1):
  - v_count=0, h_sync=~HS_ACTIVE, v_sync=~VS_ACTIVE, blank=1.
  - line_start=0, frame_start=0, seq_err=0.
  - Internal h_prev=0, prev_valid=0.
- Latency: one cycle. h_count sampled at edge k drives h_sync, blank and the pulses after edge k.
- v_count:
  - Increments at the edge where the sampled h_count == H_TOTAL-1 and the step into it was legal.
  - Wraps V_TOTAL-1 -> 0.
- Decode uses the v_count value after that edge's update. The sample with h_count=H_TOTAL-1 decodes with the old line; the following h_count=0 decodes with the new line.
- h_sync = HS_ACTIVE when H_VIS+H_FP <= h_count < H_VIS+H_FP+H_SYNC; otherwise ~HS_ACTIVE.
- v_sync = VS_ACTIVE when V_VIS+V_FP <= line < V_VIS+V_FP+V_SYNC.
- blank = 1 when h_count >= H_VIS or line >= V_VIS.
- line_start = 1 for the cycle after sampling h_count==0.
- frame_start = line_start AND line==0.
- Legal step: h_count == h_prev+1, or (h_prev == H_TOTAL-1 and h_count == 0).
  - First sample after reset (prev_valid=0) is always legal; it sets prev_valid=1.
- Illegal step (includes repeats and backward jumps):
  - seq_err=1 for one cycle; v_count does not advance that edge.
  - Decode proceeds on the sampled value, so the decoder resynchronises to the new h_count immediately.
- Out of range (h_count >= H_TOTAL): seq_err=1, blank=1, h_sync inactive, no v_count advance.
- h_prev <= h_count on every edge.
- Reset asserted mid-frame forces the reset values immediately (asynchronously). After release the decoder restarts at line 0 with no seq_err on the first sample.
- Width: comparisons are unsigned. h_prev+1 is computed 10 bits wide, so h_prev=511 gives 512, which is never equal to h_count.

Test Plan:
- rst pulse, then h_count stepped 0..263 repeatedly -> after the first 264 samples v_count=1.
  - line_start pulses once per line; blank=0 for samples 0..199 and 1 for 200..263.
  - h_sync=1 exactly for samples 210..241 (32 cycles).
- Run a full 628x264 sequence -> v_sync=1 exactly on lines 601..604.
  - blank=1 for all of lines 600..627.
  - After h_count 263 on line 627, v_count=0 and frame_start pulses on the next h_count=0.
- Sequence 10,11,12,50,51 -> seq_err high only after the 50 sample.
  - No error on 51; v_count unchanged.
- Drive h_count=300 -> seq_err=1, blank=1, h_sync=0; next sample 0 is flagged seq_err (prev 300 is not 263).
- Assert rst at line 400, pixel 100 -> outputs go to reset values before the next clk edge.
  - After release, sample h_count=57: no seq_err, v_count=0.
- HS_ACTIVE=0, VS_ACTIVE=0 build -> h_sync low during 210..241 and high otherwise; v_sync low on lines 601..604; h_sync=1 and v_sync=1 during reset.
